// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V core: widths, PC step and reset values.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO for the prefetch queue; flush beats push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_eff;

  assign pop_eff   = pop && (count_q != '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop_eff);
    end
  end

  // Storage is reset too so the head reads as zero while the core is in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential requests, in-order
// response capture into a prefetch queue, and redirect flush with stale-drop.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  input  logic               id_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + INSTR_W;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count;
  logic [CW:0]     credits_used;
  logic [EW-1:0]   head;
  logic [XLEN-1:0] redirect_aligned;
  logic            grant, resp_push, pop;

  // Handshakes: a fetch transfers when imem_req && imem_gnt; an entry moves to
  // decode when if_valid && id_ready; if_* hold while valid and not ready.
  assign credits_used     = {1'b0, count} + {1'b0, outstanding_q};
  assign imem_req         = reset && !redirect && (credits_used < (CW+1)'(DEPTH));
  assign imem_addr        = fetch_pc_q;
  assign grant            = imem_req && imem_gnt;
  assign if_valid         = (count != '0);
  assign pop              = if_valid && id_ready;
  assign resp_push        = imem_rvalid && !redirect && (drop_cnt_q == '0);
  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign {if_pc, if_instr} = head;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    drop_cnt_d    = drop_cnt_q;
    if (redirect) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      if (resp_push) resp_pc_d = resp_pc_q + XLEN'(PC_STEP);
      else if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (resp_push),
    .push_data ({resp_pc_q, imem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head_data (head)
  );

  // Credits reserve a slot for every outstanding fetch, so a push never meets a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    resp_push |-> (count < CW'(DEPTH)));
endmodule
